// File: rtl/bee526_pkg.sv
// Shared constants and types for the SRAM-attached image stages.
package bee526_pkg;

  localparam logic [7:0] INST_NOP   = 8'd0;
  localparam logic [7:0] INST_WRITE = 8'd2;
  localparam logic [7:0] INST_READ  = 8'd3;

  localparam int unsigned GS_IMG_BYTE_LENGTH  = 16384;
  localparam int unsigned RGB_IMG_BYTE_LENGTH = 49152;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StReceive,
    StFinish
  } fb_state_e;

endpackage

// File: rtl/serial_byte_assembler.sv
// Collects a serial MSB-first bit stream into bytes; o_byte_valid marks the 8th bit.
module serial_byte_assembler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clear,
  input  logic       i_bit,
  input  logic       i_strobe,
  output logic [7:0] o_byte,
  output logic       o_byte_valid
);

  logic [6:0] r_shift;
  logic [2:0] r_bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (i_clear) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (i_strobe) begin
      r_shift   <= {r_shift[5:0], i_bit};
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  // The completing bit is folded in combinationally so the byte is usable in its arrival cycle.
  assign o_byte       = {r_shift, i_bit};
  assign o_byte_valid = i_strobe && (r_bit_cnt == 3'd7);

endmodule

// File: rtl/foreground_bbox.sv
// Reads the foreground mask serially from SRAM and reduces it to count, bounding box and motion.
module foreground_bbox
  import bee526_pkg::*;
#(
  parameter int unsigned IMG_W      = 128,
  parameter int unsigned IMG_H      = 128,
  parameter logic [7:0]  READ_INST  = INST_READ,
  parameter int unsigned MIN_PIXELS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  sram_select_in,
  input  logic [23:0] mask_address,
  input  logic        execute,
  input  logic [3:0]  mem_out,
  input  logic [3:0]  io_valid,
  input  logic [3:0]  rw_done,
  output logic [7:0]  inst        [0:3],
  output logic [23:0] address     [0:3],
  output logic [23:0] byte_length [0:3],
  output logic        job_done,
  output logic        error,
  output logic [14:0] fg_count,
  output logic [6:0]  x_min,
  output logic [6:0]  x_max,
  output logic [6:0]  y_min,
  output logic [6:0]  y_max,
  output logic        bbox_valid,
  output logic        motion
);

  localparam logic [14:0] TOTAL    = 15'(IMG_W * IMG_H);
  localparam logic [23:0] BYTE_LEN = 24'(IMG_W * IMG_H);
  localparam logic [6:0]  X_LAST   = 7'(IMG_W - 1);

  fb_state_e   r_state;
  logic [1:0]  r_ch;
  logic [14:0] r_p;
  logic [6:0]  r_x, r_y;
  logic [14:0] r_count;
  logic [6:0]  r_xmin, r_xmax, r_ymin, r_ymax;
  logic        r_short;

  logic [1:0]  w_sel_ch;
  logic        w_strobe, w_byte_valid, w_fg, w_done;
  logic [7:0]  w_byte;
  logic [14:0] w_p_next;

  assign w_sel_ch = sram_select_in + 2'd1;
  // Bits beyond the last pixel never reach the assembler.
  assign w_strobe = (r_state == StReceive) && io_valid[r_ch] && (r_p != TOTAL);
  assign w_done   = (r_state == StReceive) && rw_done[r_ch];
  assign w_fg     = w_byte_valid && (w_byte != 8'd0);
  assign w_p_next = r_p + 15'(w_byte_valid);

  serial_byte_assembler u_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (r_state == StIdle),
    .i_bit       (mem_out[r_ch]),
    .i_strobe    (w_strobe),
    .o_byte      (w_byte),
    .o_byte_valid(w_byte_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_ch       <= '0;
      r_p        <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_count    <= '0;
      r_xmin     <= '0;
      r_xmax     <= '0;
      r_ymin     <= '0;
      r_ymax     <= '0;
      r_short    <= 1'b0;
      job_done   <= 1'b0;
      error      <= 1'b0;
      fg_count   <= '0;
      x_min      <= '0;
      x_max      <= '0;
      y_min      <= '0;
      y_max      <= '0;
      bbox_valid <= 1'b0;
      motion     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        inst[i]        <= INST_NOP;
        address[i]     <= '0;
        byte_length[i] <= '0;
      end
    end else begin
      job_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (execute) begin
            r_state               <= StIssue;
            r_ch                  <= w_sel_ch;
            r_p                   <= '0;
            r_x                   <= '0;
            r_y                   <= '0;
            r_count               <= '0;
            r_xmin                <= 7'd127;
            r_ymin                <= 7'd127;
            r_xmax                <= '0;
            r_ymax                <= '0;
            inst[w_sel_ch]        <= READ_INST;
            address[w_sel_ch]     <= mask_address;
            byte_length[w_sel_ch] <= BYTE_LEN;
          end
        end
        StIssue: begin
          inst[r_ch] <= INST_NOP;
          r_state    <= StReceive;
        end
        StReceive: begin
          if (w_byte_valid) begin
            r_p <= w_p_next;
            if (r_x == X_LAST) begin
              r_x <= '0;
              r_y <= r_y + 7'd1;
            end else begin
              r_x <= r_x + 7'd1;
            end
            if (w_fg) begin
              r_count <= r_count + 15'd1;
              if (r_x < r_xmin) r_xmin <= r_x;
              if (r_x > r_xmax) r_xmax <= r_x;
              if (r_y < r_ymin) r_ymin <= r_y;
              if (r_y > r_ymax) r_ymax <= r_y;
            end
          end
          // Completeness uses the pixel index including a byte finishing this cycle.
          if (w_done) begin
            r_state <= StFinish;
            r_short <= (w_p_next != TOTAL);
          end
        end
        StFinish: begin
          fg_count   <= r_count;
          bbox_valid <= (r_count != 15'd0);
          motion     <= (r_count >= 15'(MIN_PIXELS));
          error      <= r_short;
          job_done   <= 1'b1;
          if (r_count != 15'd0) begin
            x_min <= r_xmin;
            x_max <= r_xmax;
            y_min <= r_ymin;
            y_max <= r_ymax;
          end else begin
            x_min <= '0;
            x_max <= '0;
            y_min <= '0;
            y_max <= '0;
          end
          for (int i = 0; i < 4; i++) begin
            inst[i]        <= INST_NOP;
            address[i]     <= '0;
            byte_length[i] <= '0;
          end
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_foreground_bbox.sv
// Directed bench for foreground_bbox on a 128x10 image to keep full-frame jobs short.
module tb_foreground_bbox;

  localparam int IMG_W = 128;
  localparam int IMG_H = 10;
  localparam int TOTAL = IMG_W * IMG_H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  sram_select_in = '0;
  logic [23:0] mask_address = '0;
  logic        execute = 1'b0;
  logic [3:0]  mem_out = '0;
  logic [3:0]  io_valid = '0;
  logic [3:0]  rw_done = '0;
  logic [7:0]  inst        [0:3];
  logic [23:0] address     [0:3];
  logic [23:0] byte_length [0:3];
  logic        job_done, error, bbox_valid, motion;
  logic [14:0] fg_count;
  logic [6:0]  x_min, x_max, y_min, y_max;

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;
  int issue_cycles = 0;
  int ch = 0;

  logic [7:0]  snap_inst [0:3];
  logic [23:0] snap_addr [0:3];
  logic [23:0] snap_len  [0:3];
  logic [7:0]  rx_inst;
  logic [23:0] rx_addr, rx_len;

  foreground_bbox #(
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .READ_INST (8'd3),
    .MIN_PIXELS(16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sram_select_in(sram_select_in),
    .mask_address  (mask_address),
    .execute       (execute),
    .mem_out       (mem_out),
    .io_valid      (io_valid),
    .rw_done       (rw_done),
    .inst          (inst),
    .address       (address),
    .byte_length   (byte_length),
    .job_done      (job_done),
    .error         (error),
    .fg_count      (fg_count),
    .x_min         (x_min),
    .x_max         (x_max),
    .y_min         (y_min),
    .y_max         (y_max),
    .bbox_valid    (bbox_valid),
    .motion        (motion)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (job_done === 1'b1) done_pulses++;
    if (inst[ch] === 8'd3) issue_cycles++;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation still running at %0t, limit 1500000", $time);
    $fatal(1);
  end

  // Other channels see random strobes and rw_done, which must be ignored.
  task automatic send_byte(input logic [7:0] b, input bit done_last);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      io_valid    = 4'hF;
      mem_out     = 4'($urandom);
      rw_done     = 4'($urandom);
      mem_out[ch] = b[i];
      rw_done[ch] = done_last && (i == 0);
    end
  endtask

  task automatic send_image(input int ia, input logic [7:0] va, input int ib,
                            input logic [7:0] vb, input logic [7:0] fill, input bit done_last);
    logic [7:0] b;
    for (int p = 0; p < TOTAL; p++) begin
      b = fill;
      if (p == ia) b = va;
      if (p == ib) b = vb;
      send_byte(b, done_last && (p == TOTAL - 1));
    end
  endtask

  task automatic start_job(input logic [1:0] sel, input logic [23:0] addr, input bit hold_exec);
    @(negedge clk);
    ch = (int'(sel) + 1) % 4;
    sram_select_in = sel;
    mask_address = addr;
    execute = 1'b1;
    @(negedge clk);
    if (!hold_exec) execute = 1'b0;
    for (int i = 0; i < 4; i++) begin
      snap_inst[i] = inst[i];
      snap_addr[i] = address[i];
      snap_len[i]  = byte_length[i];
    end
    @(negedge clk);
    rx_inst = inst[ch];
    rx_addr = address[ch];
    rx_len  = byte_length[ch];
  endtask

  task automatic finish_job(input bit raise_done, output bit seen);
    seen = 1'b0;
    if (raise_done) begin
      @(negedge clk);
      io_valid = '0;
      rw_done = '0;
      rw_done[ch] = 1'b1;
    end
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      io_valid = '0;
      rw_done = '0;
      if (job_done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({job_done, error, bbox_valid, motion, fg_count} !== 19'd0) begin
      errors++;
      $display("FAIL reset flags/count: got %h, want 0", {job_done, error, bbox_valid, motion, fg_count});
    end
    checks++;
    if ({x_min, x_max, y_min, y_max} !== 28'd0) begin
      errors++;
      $display("FAIL reset bbox: got %h, want 0", {x_min, x_max, y_min, y_max});
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({inst[i], address[i], byte_length[i]} !== 56'd0) begin
        errors++;
        $display("FAIL reset ch%0d bus: got %h, want 0", i, {inst[i], address[i], byte_length[i]});
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_all_zero;
    bit seen;
    int d0;
    d0 = done_pulses;
    start_job(2'd0, 24'h001000, 1'b0);
    checks++;
    if ({snap_inst[1], snap_addr[1], snap_len[1]} !== {8'd3, 24'h001000, 24'd1280}) begin
      errors++;
      $display("FAIL zero issue ch1: got %h, want %h", {snap_inst[1], snap_addr[1], snap_len[1]},
               {8'd3, 24'h001000, 24'd1280});
    end
    checks++;
    if ({rx_inst, rx_addr, rx_len} !== {8'd0, 24'h001000, 24'd1280}) begin
      errors++;
      $display("FAIL zero receive ch1: got %h, want %h", {rx_inst, rx_addr, rx_len},
               {8'd0, 24'h001000, 24'd1280});
    end
    send_image(-1, 8'h00, -1, 8'h00, 8'h00, 1'b0);
    finish_job(1'b1, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL zero job_done: got none within 20 cycles, want pulse");
    end
    checks++;
    if ({error, bbox_valid, motion, fg_count, x_min, x_max, y_min, y_max} !== 46'd0) begin
      errors++;
      $display("FAIL zero results: got %h, want 0",
               {error, bbox_valid, motion, fg_count, x_min, x_max, y_min, y_max});
    end
    checks++;
    if ({address[1], byte_length[1]} !== 48'd0) begin
      errors++;
      $display("FAIL zero bus cleared: got %h, want 0", {address[1], byte_length[1]});
    end
    @(negedge clk);
    checks++;
    if (job_done !== 1'b0) begin
      errors++;
      $display("FAIL zero pulse width: job_done got %b, want 0", job_done);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done_pulses != d0 + 1) begin
      errors++;
      $display("FAIL zero pulse count: got %0d, want %0d", done_pulses - d0, 1);
    end
  endtask

  task automatic test_single;
    bit seen;
    start_job(2'd2, 24'h0ABCDE, 1'b0);
    send_image(1157, 8'h01, -1, 8'h00, 8'h00, 1'b0);
    finish_job(1'b1, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL single job_done: got none, want pulse");
    end
    checks++;
    if ({error, bbox_valid, motion, fg_count} !== {1'b0, 1'b1, 1'b0, 15'd1}) begin
      errors++;
      $display("FAIL single flags/count: err=%b valid=%b motion=%b count=%0d, want 0 1 0 1",
               error, bbox_valid, motion, fg_count);
    end
    checks++;
    if ({x_min, x_max, y_min, y_max} !== {7'd5, 7'd5, 7'd9, 7'd9}) begin
      errors++;
      $display("FAIL single bbox: got x %0d..%0d y %0d..%0d, want x 5..5 y 9..9",
               x_min, x_max, y_min, y_max);
    end
  endtask

  task automatic test_corners;
    bit seen;
    start_job(2'd3, 24'h123456, 1'b0);
    checks++;
    if (snap_inst[0] !== 8'd3) begin
      errors++;
      $display("FAIL corners issue inst0: got %0d, want 3", snap_inst[0]);
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if ({snap_inst[i], snap_addr[i], snap_len[i]} !== 56'd0) begin
        errors++;
        $display("FAIL corners idle ch%0d: got %h, want 0", i, {snap_inst[i], snap_addr[i], snap_len[i]});
      end
    end
    // Last bit and rw_done coincide: the final byte must still count and the job be complete.
    send_image(0, 8'hFF, TOTAL - 1, 8'hFF, 8'h00, 1'b1);
    finish_job(1'b0, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL corners job_done: got none, want pulse");
    end
    checks++;
    if ({error, bbox_valid, motion, fg_count} !== {1'b0, 1'b1, 1'b0, 15'd2}) begin
      errors++;
      $display("FAIL corners flags/count: err=%b valid=%b motion=%b count=%0d, want 0 1 0 2",
               error, bbox_valid, motion, fg_count);
    end
    checks++;
    if ({x_min, x_max, y_min, y_max} !== {7'd0, 7'd127, 7'd0, 7'd9}) begin
      errors++;
      $display("FAIL corners bbox: got x %0d..%0d y %0d..%0d, want x 0..127 y 0..9",
               x_min, x_max, y_min, y_max);
    end
  endtask

  task automatic test_partial;
    bit seen;
    start_job(2'd0, 24'h000200, 1'b0);
    for (int p = 0; p < 100; p++) send_byte((p % 4 == 0) ? 8'h22 : 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      io_valid = '0;
      rw_done = '0;
      io_valid[ch] = 1'b1;
      mem_out[ch] = 1'b1;
    end
    finish_job(1'b1, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL partial job_done: got none, want pulse");
    end
    checks++;
    if ({error, bbox_valid, motion, fg_count} !== {1'b1, 1'b1, 1'b1, 15'd25}) begin
      errors++;
      $display("FAIL partial flags/count: err=%b valid=%b motion=%b count=%0d, want 1 1 1 25",
               error, bbox_valid, motion, fg_count);
    end
    checks++;
    if ({x_min, x_max, y_min, y_max} !== {7'd0, 7'd96, 7'd0, 7'd0}) begin
      errors++;
      $display("FAIL partial bbox: got x %0d..%0d y %0d..%0d, want x 0..96 y 0..0",
               x_min, x_max, y_min, y_max);
    end
  endtask

  task automatic test_full;
    bit seen;
    start_job(2'd1, 24'h004000, 1'b0);
    send_image(-1, 8'h00, -1, 8'h00, 8'h80, 1'b0);
    send_byte(8'hFF, 1'b0);
    finish_job(1'b1, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL full job_done: got none, want pulse");
    end
    checks++;
    if ({error, bbox_valid, motion, fg_count} !== {1'b0, 1'b1, 1'b1, 15'd1280}) begin
      errors++;
      $display("FAIL full flags/count: err=%b valid=%b motion=%b count=%0d, want 0 1 1 1280",
               error, bbox_valid, motion, fg_count);
    end
    checks++;
    if ({x_min, x_max, y_min, y_max} !== {7'd0, 7'd127, 7'd0, 7'd9}) begin
      errors++;
      $display("FAIL full bbox: got x %0d..%0d y %0d..%0d, want x 0..127 y 0..9",
               x_min, x_max, y_min, y_max);
    end
  endtask

  task automatic test_reset_mid_job;
    bit seen;
    int d0, i0;
    start_job(2'd2, 24'h00ABCD, 1'b0);
    for (int p = 0; p < 20; p++) send_byte(8'hFF, 1'b0);
    d0 = done_pulses;
    @(negedge clk);
    io_valid = '0;
    rw_done = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({job_done, error, bbox_valid, motion, fg_count, x_max, y_max} !== 33'd0) begin
      errors++;
      $display("FAIL midreset outputs: got %h, want 0",
               {job_done, error, bbox_valid, motion, fg_count, x_max, y_max});
    end
    checks++;
    if ({address[3], byte_length[3]} !== 48'd0) begin
      errors++;
      $display("FAIL midreset bus ch3: got %h, want 0", {address[3], byte_length[3]});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (done_pulses != d0) begin
      errors++;
      $display("FAIL midreset job_done: got %0d pulses, want 0", done_pulses - d0);
    end
    i0 = issue_cycles;
    start_job(2'd0, 24'h000777, 1'b1);
    send_image(0, 8'h10, 1157, 8'h01, 8'h00, 1'b0);
    execute = 1'b0;
    finish_job(1'b1, seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL clean job_done: got none, want pulse");
    end
    checks++;
    if (issue_cycles != i0 + 1) begin
      errors++;
      $display("FAIL clean issue cycles: got %0d, want 1", issue_cycles - i0);
    end
    checks++;
    if ({error, bbox_valid, motion, fg_count} !== {1'b0, 1'b1, 1'b0, 15'd2}) begin
      errors++;
      $display("FAIL clean flags/count: err=%b valid=%b motion=%b count=%0d, want 0 1 0 2",
               error, bbox_valid, motion, fg_count);
    end
    checks++;
    if ({x_min, x_max, y_min, y_max} !== {7'd0, 7'd5, 7'd0, 7'd9}) begin
      errors++;
      $display("FAIL clean bbox: got x %0d..%0d y %0d..%0d, want x 0..5 y 0..9",
               x_min, x_max, y_min, y_max);
    end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_single();
    test_corners();
    test_partial();
    test_full();
    test_reset_mid_job();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
